// File: rtl/game_pkg.sv
// Shared types and helpers for the memory-sequence game blocks.
// Holds the FSM state encoding, default sizes and the symbol-to-LED decoder.
package game_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int SYM_W_DEF = 2;
  localparam int MAX_SYM_W = 4;
  localparam int MAX_LEDS  = 1 << MAX_SYM_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_GAP,
    ST_DONE
  } state_t;

  // Callers zero-extend their symbol and truncate the result to their LED count.
  function automatic logic [MAX_LEDS-1:0] sym_onehot(input logic [MAX_SYM_W-1:0] sym);
    logic [MAX_LEDS-1:0] oh;
    oh      = '0;
    oh[sym] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/seq_mem.sv
// Sequence storage: DEPTH x W register file, one write port, one asynchronous read.
// Not reset, so a stored sequence survives a game reset.
module seq_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write to the loaded entry shows the old value.
  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/sequence_player.sv
// Replays the stored colour sequence on one-hot LEDs, one lit and one dark tick interval per step.
// Runs the speed timer through timer_en and only advances on its returned tick.
module sequence_player
  import game_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SYM_W = SYM_W_DEF,
  parameter int LEN_W = 5,
  localparam int AW   = $clog2(DEPTH),
  localparam int LEDS = 1 << SYM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [SYM_W-1:0] wr_data,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic             tick,
  output logic             timer_en,
  output logic [LEDS-1:0]  led,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [AW-1:0]    index_reg, index_next;
  logic [LEN_W-1:0] eff_len_reg, eff_len_next;
  logic [LEDS-1:0]  led_reg, led_next;
  logic             timer_en_reg, timer_en_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic [AW-1:0]    rd_addr;
  logic [SYM_W-1:0] rd_data;
  logic [LEDS-1:0]  led_load;
  logic [LEN_W-1:0] clamped_len;
  logic             is_last;

  seq_mem #(
    .DEPTH(DEPTH),
    .W    (SYM_W),
    .AW   (AW)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // The single read port looks ahead to the entry the next SHOW will display.
  assign rd_addr     = (state_reg == ST_GAP) ? index_reg + AW'(1) : '0;
  assign led_load    = LEDS'(sym_onehot(MAX_SYM_W'(rd_data)));
  assign clamped_len = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;
  assign is_last     = (LEN_W'(index_reg) == eff_len_reg - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      index_reg    <= '0;
      eff_len_reg  <= '0;
      led_reg      <= '0;
      timer_en_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      index_reg    <= index_next;
      eff_len_reg  <= eff_len_next;
      led_reg      <= led_next;
      timer_en_reg <= timer_en_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    index_next    = index_reg;
    eff_len_next  = eff_len_reg;
    led_next      = led_reg;
    timer_en_next = timer_en_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          busy_next = 1'b1;
          if (length == '0) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            state_next    = ST_SHOW;
            index_next    = '0;
            eff_len_next  = clamped_len;
            led_next      = led_load;
            timer_en_next = 1'b1;
          end
        end
      end
      ST_SHOW: begin
        if (tick) begin
          led_next   = '0;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (is_last) begin
            timer_en_next = 1'b0;
            done_next     = 1'b1;
            state_next    = ST_DONE;
          end else begin
            index_next = index_reg + AW'(1);
            led_next   = led_load;
            state_next = ST_SHOW;
          end
        end
      end
      ST_DONE: begin
        busy_next     = 1'b0;
        timer_en_next = 1'b0;
        led_next      = '0;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign led      = led_reg;
  assign timer_en = timer_en_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule
